// File: rtl/uart_apb_regs_fifo_if.sv
// rtl/uart_apb_regs_fifo_if.sv - APB register bus bundle for the UART register block
interface uart_apb_regs_fifo_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/uart_apb_regs_fifo.sv
// rtl/uart_apb_regs_fifo.sv - UART APB register block with TX/RX FIFOs, sticky flags and irq
module uart_apb_regs_fifo #(
    parameter logic [31:0]       BASE_ADDR  = 32'h40070050,
    parameter int                DATA_W     = 8,
    parameter int                FIFO_DEPTH = 16,
    parameter int                BAUD_W     = 16,
    parameter logic [BAUD_W-1:0] BAUD_RST   = BAUD_W'(27)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_apb_regs_fifo_if.slave  apb,
    output logic [DATA_W-1:0]    tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    input  logic [DATA_W-1:0]    rx_data_i,
    input  logic                 rx_valid_i,
    input  logic                 parity_error_i,
    input  logic                 frame_error_i,
    output logic [BAUD_W-1:0]    baud_div_o,
    output logic                 irq_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] THR_MAX = CNT_W'(FIFO_DEPTH - 1);

    // storage and state
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [PTR_W-1:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [3:0]        flags_q, flags_d;   // [0] RX_OVR [1] PAR_ERR [2] FRM_ERR [3] TX_OVF
    logic [2:0]        ie_q, ie_d;
    logic [2:0]        thr_q, thr_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              irq_q, irq_d;

    // bus decode
    logic acc, wr, rd;
    logic sel_rxd, sel_txd, sel_stat, sel_ctrl, sel_baud, sel_lvl, sel_any;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_pop, tx_wr, tx_push, tx_ovf_set, tx_flush;
    logic rx_pop, rx_push, rx_ovr_set, rx_flush;
    logic [3:0] w1c, flag_set;
    logic [CNT_W-1:0] thr_eff;
    logic rx_ge_thr;
    logic [8:0] stat;
    logic [31:0] prdata_c;
    logic unused_pwdata;

    assign acc = apb.psel & apb.penable;
    assign wr  = acc & apb.pwrite;
    assign rd  = acc & ~apb.pwrite;

    assign sel_rxd  = (apb.paddr == BASE_ADDR + 32'h00);
    assign sel_txd  = (apb.paddr == BASE_ADDR + 32'h04);
    assign sel_stat = (apb.paddr == BASE_ADDR + 32'h08);
    assign sel_ctrl = (apb.paddr == BASE_ADDR + 32'h0C);
    assign sel_baud = (apb.paddr == BASE_ADDR + 32'h10);
    assign sel_lvl  = (apb.paddr == BASE_ADDR + 32'h14);
    assign sel_any  = sel_rxd | sel_txd | sel_stat | sel_ctrl | sel_baud | sel_lvl;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == DEPTH_C);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == DEPTH_C);

    // a full TX FIFO still accepts a write when the engine pops in the same cycle
    assign tx_pop     = tx_valid_o & tx_ready_i;
    assign tx_wr      = wr & sel_txd;
    assign tx_push    = tx_wr & (~tx_full | tx_pop);
    assign tx_ovf_set = tx_wr & tx_full & ~tx_pop;
    assign tx_flush   = wr & sel_ctrl & apb.pwdata[9];

    // likewise a full RX FIFO accepts a character when the bus pops in the same cycle
    assign rx_pop     = rd & sel_rxd & ~rx_empty;
    assign rx_push    = rx_valid_i & (~rx_full | rx_pop);
    assign rx_flush   = wr & sel_ctrl & apb.pwdata[8];
    assign rx_ovr_set = rx_valid_i & rx_full & ~rx_pop & ~rx_flush;

    assign w1c      = (wr & sel_stat) ? apb.pwdata[7:4] : 4'd0;
    assign flag_set = {tx_ovf_set, rx_valid_i & frame_error_i, rx_valid_i & parity_error_i, rx_ovr_set};

    // threshold clamped into 1..FIFO_DEPTH-1
    always_comb begin
        thr_eff = CNT_W'(thr_q);
        if (thr_q == 3'd0) begin
            thr_eff = CNT_W'(1);
        end else if ({29'd0, thr_q} > 32'(FIFO_DEPTH - 1)) begin
            thr_eff = THR_MAX;
        end
    end

    assign rx_ge_thr = (rx_cnt_q >= thr_eff);
    assign stat      = {rx_ge_thr, flags_q, tx_full, tx_empty, rx_full, ~rx_empty};

    // TX FIFO pointer/count next state; flush overrides any same-cycle traffic
    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_flush) begin
            tx_wr_d  = '0;
            tx_rd_d  = '0;
            tx_cnt_d = '0;
        end else begin
            if (tx_push) tx_wr_d = tx_wr_q + PTR_W'(1);
            if (tx_pop)  tx_rd_d = tx_rd_q + PTR_W'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt_d = tx_cnt_q + CNT_W'(1);
                2'b01:   tx_cnt_d = tx_cnt_q - CNT_W'(1);
                default: tx_cnt_d = tx_cnt_q;
            endcase
        end
    end

    // RX FIFO pointer/count next state; flush overrides any same-cycle traffic
    always_comb begin
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_flush) begin
            rx_wr_d  = '0;
            rx_rd_d  = '0;
            rx_cnt_d = '0;
        end else begin
            if (rx_push) rx_wr_d = rx_wr_q + PTR_W'(1);
            if (rx_pop)  rx_rd_d = rx_rd_q + PTR_W'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt_d = rx_cnt_q + CNT_W'(1);
                2'b01:   rx_cnt_d = rx_cnt_q - CNT_W'(1);
                default: rx_cnt_d = rx_cnt_q;
            endcase
        end
    end

    // control registers, sticky flags (set beats clear) and interrupt condition
    always_comb begin
        flags_d = (flags_q & ~w1c) | flag_set;
        ie_d    = ie_q;
        thr_d   = thr_q;
        baud_d  = baud_q;
        if (wr & sel_ctrl) begin
            ie_d  = apb.pwdata[2:0];
            thr_d = apb.pwdata[5:3];
        end
        if (wr & sel_baud) begin
            baud_d = apb.pwdata[BAUD_W-1:0];
        end
        irq_d = (ie_q[0] & rx_ge_thr) | (ie_q[1] & tx_empty) | (ie_q[2] & (|flags_q));
    end

    // register state update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            flags_q  <= '0;
            ie_q     <= '0;
            thr_q    <= '0;
            baud_q   <= BAUD_RST;
            irq_q    <= 1'b0;
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            flags_q  <= flags_d;
            ie_q     <= ie_d;
            thr_q    <= thr_d;
            baud_q   <= baud_d;
            irq_q    <= irq_d;
        end
    end

    // FIFO data arrays; contents need no reset since counts gate visibility
    always_ff @(posedge clk) begin
        if (tx_push && !tx_flush) tx_mem[tx_wr_q] <= apb.pwdata[DATA_W-1:0];
        if (rx_push && !rx_flush) rx_mem[rx_wr_q] <= rx_data_i;
    end

    // read mux follows paddr while selected, independent of penable
    always_comb begin
        prdata_c = '0;
        if (apb.psel) begin
            if (sel_rxd && !rx_empty) begin
                prdata_c[DATA_W-1:0] = rx_mem[rx_rd_q];
            end else if (sel_stat) begin
                prdata_c[8:0] = stat;
            end else if (sel_ctrl) begin
                prdata_c[5:0] = {thr_q, ie_q};
            end else if (sel_baud) begin
                prdata_c[BAUD_W-1:0] = baud_q;
            end else if (sel_lvl) begin
                prdata_c[CNT_W-1:0]    = rx_cnt_q;
                prdata_c[16 +: CNT_W]  = tx_cnt_q;
            end
        end
    end

    assign apb.prdata  = prdata_c;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = acc & (~sel_any | (sel_rxd & ~apb.pwrite & rx_empty) | tx_ovf_set);

    assign unused_pwdata = ^apb.pwdata;

    assign tx_valid_o = ~tx_empty;
    assign tx_data_o  = tx_mem[tx_rd_q];
    assign baud_div_o = baud_q;
    assign irq_o      = irq_q;
endmodule

// File: tb/tb_uart_apb_regs_fifo.sv
// tb/tb_uart_apb_regs_fifo.sv - self-checking bench for uart_apb_regs_fifo
module tb_uart_apb_regs_fifo;
    localparam logic [31:0] BASE = 32'h40070050;
    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        parity_error = 1'b0;
    logic        frame_error = 1'b0;
    logic [15:0] baud_div_o;
    logic        irq_o;

    int n_tests = 0;
    int n_fail  = 0;

    uart_apb_regs_fifo_if apb();

    uart_apb_regs_fifo dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .apb            (apb),
        .tx_data_o      (tx_data_o),
        .tx_valid_o     (tx_valid_o),
        .tx_ready_i     (tx_ready),
        .rx_data_i      (rx_data),
        .rx_valid_i     (rx_valid),
        .parity_error_i (parity_error),
        .frame_error_i  (frame_error),
        .baud_div_o     (baud_div_o),
        .irq_o          (irq_o)
    );

    always #5 clk = ~clk;

    // reference model: queues for the FIFOs plus plain register copies
    logic [7:0]  m_rx[$];
    logic [7:0]  m_tx[$];
    bit          m_ovr, m_par, m_frm, m_txovf, m_irq;
    logic [2:0]  m_ie, m_thr;
    logic [15:0] m_baud;
    logic [7:0]  s_txd;
    bit          s_txv, s_irq;

    task automatic model_reset();
        m_rx.delete();
        m_tx.delete();
        m_ovr = 0; m_par = 0; m_frm = 0; m_txovf = 0; m_irq = 0;
        m_ie = 3'd0; m_thr = 3'd0; m_baud = 16'd27;
    endtask

    function automatic int eff_thr();
        if (m_thr == 3'd0) return 1;
        if (int'(m_thr) > D - 1) return D - 1;
        return int'(m_thr);
    endfunction

    function automatic logic [31:0] m_prdata(input bit sel, input logic [31:0] addr);
        logic [31:0] off;
        logic [31:0] v;
        off = addr - BASE;
        v = 32'd0;
        if (sel) begin
            case (off)
                32'h00: if (m_rx.size() > 0) v = {24'd0, m_rx[0]};
                32'h08: v = {23'd0, m_rx.size() >= eff_thr(), m_txovf, m_frm, m_par, m_ovr,
                             m_tx.size() == D, m_tx.size() == 0, m_rx.size() == D, m_rx.size() > 0};
                32'h0C: v = {26'd0, m_thr, m_ie};
                32'h10: v = {16'd0, m_baud};
                32'h14: v = {11'd0, 5'(m_tx.size()), 11'd0, 5'(m_rx.size())};
                default: v = 32'd0;
            endcase
        end
        return v;
    endfunction

    function automatic bit m_err(input bit wr, input logic [31:0] addr, input bit txr);
        logic [31:0] off;
        off = addr - BASE;
        case (off)
            32'h00: return !wr && m_rx.size() == 0;
            32'h04: return wr && m_tx.size() == D && !txr;
            32'h08, 32'h0C, 32'h10, 32'h14: return 0;
            default: return 1;
        endcase
    endfunction

    task automatic model_step(input int ph, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                              input bit rxv, input logic [7:0] rxd, input bit pe, input bit fe, input bit txr);
        bit acc, cond, txpop, rxpop, txfl, rxfl;
        int sz;
        logic [31:0] off;
        acc = (ph == 2);
        off = addr - BASE;
        cond = (m_ie[0] && m_rx.size() >= eff_thr()) || (m_ie[1] && m_tx.size() == 0) ||
               (m_ie[2] && (m_ovr || m_par || m_frm || m_txovf));
        txpop = txr && m_tx.size() > 0;
        rxpop = acc && !wr && off == 32'h00 && m_rx.size() > 0;
        txfl  = acc && wr && off == 32'h0C && wd[9];
        rxfl  = acc && wr && off == 32'h0C && wd[8];
        if (acc && wr && off == 32'h08) begin
            if (wd[4]) m_ovr = 0;
            if (wd[5]) m_par = 0;
            if (wd[6]) m_frm = 0;
            if (wd[7]) m_txovf = 0;
        end
        if (txfl) m_tx.delete();
        else begin
            sz = m_tx.size();
            if (txpop) void'(m_tx.pop_front());
            if (acc && wr && off == 32'h04) begin
                if (sz < D || txpop) m_tx.push_back(wd[7:0]);
                else m_txovf = 1;
            end
        end
        if (rxfl) m_rx.delete();
        else begin
            sz = m_rx.size();
            if (rxpop) void'(m_rx.pop_front());
            if (rxv) begin
                if (sz < D || rxpop) m_rx.push_back(rxd);
                else m_ovr = 1;
            end
        end
        if (rxv && pe) m_par = 1;
        if (rxv && fe) m_frm = 1;
        if (acc && wr && off == 32'h0C) begin
            m_ie  = wd[2:0];
            m_thr = wd[5:3];
        end
        if (acc && wr && off == 32'h10) m_baud = wd[15:0];
        m_irq = cond;
    endtask

    // one clock cycle: drive at negedge, sample/check 2 ns later, then advance the model
    task automatic cycle(input int ph, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input bit rxv, input logic [7:0] rxd, input bit pe, input bit fe, input bit txr,
                         output logic [31:0] rdata, output logic err);
        logic [31:0] e_rd;
        logic        e_err;
        @(negedge clk);
        apb.psel    = (ph != 0);
        apb.penable = (ph == 2);
        apb.pwrite  = wr;
        apb.paddr   = addr;
        apb.pwdata  = wd;
        rx_valid = rxv; rx_data = rxd; parity_error = pe; frame_error = fe; tx_ready = txr;
        #2;
        e_rd  = m_prdata(ph != 0, addr);
        e_err = m_err(wr, addr, txr);
        rdata = apb.prdata;
        err   = apb.pslverr;
        s_txd = tx_data_o; s_txv = tx_valid_o; s_irq = irq_o;
        n_tests++;
        if (apb.prdata !== e_rd) begin
            n_fail++;
            $display("FAIL prdata addr=%h: got %h expected %h", addr, apb.prdata, e_rd);
        end
        if (ph == 2) begin
            n_tests++;
            if (apb.pslverr !== e_err) begin
                n_fail++;
                $display("FAIL pslverr addr=%h wr=%0d: got %b expected %b", addr, wr, apb.pslverr, e_err);
            end
        end
        n_tests++;
        if (tx_valid_o !== (m_tx.size() > 0)) begin
            n_fail++;
            $display("FAIL tx_valid: got %b expected %b", tx_valid_o, m_tx.size() > 0);
        end
        if (m_tx.size() > 0) begin
            n_tests++;
            if (tx_data_o !== m_tx[0]) begin
                n_fail++;
                $display("FAIL tx_data: got %h expected %h", tx_data_o, m_tx[0]);
            end
        end
        n_tests++;
        if (irq_o !== m_irq) begin
            n_fail++;
            $display("FAIL irq: got %b expected %b", irq_o, m_irq);
        end
        n_tests++;
        if (baud_div_o !== m_baud) begin
            n_fail++;
            $display("FAIL baud_div: got %h expected %h", baud_div_o, m_baud);
        end
        model_step(ph, wr, addr, wd, rxv, rxd, pe, fe, txr);
    endtask

    task automatic idle(input bit rxv, input logic [7:0] rxd, input bit pe, input bit fe, input bit txr);
        logic [31:0] d;
        logic e;
        cycle(0, 0, BASE, 32'd0, rxv, rxd, pe, fe, txr, d, e);
    endtask

    task automatic apb_wr(input logic [31:0] addr, input logic [31:0] wd, output logic err);
        logic [31:0] d;
        logic e;
        cycle(1, 1, addr, wd, 0, 8'd0, 0, 0, 0, d, e);
        cycle(2, 1, addr, wd, 0, 8'd0, 0, 0, 0, d, err);
    endtask

    task automatic apb_rd(input logic [31:0] addr, output logic [31:0] data, output logic err);
        logic [31:0] d;
        logic e;
        cycle(1, 0, addr, 32'd0, 0, 8'd0, 0, 0, 0, d, e);
        cycle(2, 0, addr, 32'd0, 0, 8'd0, 0, 0, 0, data, err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        apb.psel = 0; apb.penable = 0; apb.pwrite = 0; apb.paddr = 32'd0; apb.pwdata = 32'd0;
        rx_valid = 0; rx_data = 8'd0; parity_error = 0; frame_error = 0; tx_ready = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic e;
        do_reset();
        idle(0, 8'd0, 0, 0, 0);
        n_tests++;
        if (s_irq !== 1'b0 || s_txv !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got irq=%b tx_valid=%b expected 0 0", s_irq, s_txv);
        end
        apb_rd(BASE + 32'h08, d, e);
        n_tests++;
        if (d !== 32'h004) begin n_fail++; $display("FAIL reset_stat: got %h expected 004", d); end
        apb_rd(BASE + 32'h14, d, e);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_level: got %h expected 0", d); end
        apb_rd(BASE + 32'h10, d, e);
        n_tests++;
        if (d !== 32'd27) begin n_fail++; $display("FAIL reset_baud: got %0d expected 27", d); end
        apb_rd(BASE, d, e);
        n_tests++;
        if (d !== 32'h0 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rx_empty_read: got data=%h err=%b expected 0 1", d, e);
        end
    endtask

    task automatic test_tx_fill();
        logic [31:0] d;
        logic e;
        do_reset();
        for (int i = 0; i < 16; i++) apb_wr(BASE + 32'h04, 32'h41 + i, e);
        apb_rd(BASE + 32'h14, d, e);
        n_tests++;
        if (d[31:16] !== 16'd16) begin n_fail++; $display("FAIL tx_count_full: got %0d expected 16", d[31:16]); end
        apb_rd(BASE + 32'h08, d, e);
        n_tests++;
        if (d[3] !== 1'b1) begin n_fail++; $display("FAIL tx_full_flag: got %b expected 1", d[3]); end
        apb_wr(BASE + 32'h04, 32'h99, e);
        n_tests++;
        if (e !== 1'b1) begin n_fail++; $display("FAIL tx_overflow_err: got %b expected 1", e); end
        apb_rd(BASE + 32'h08, d, e);
        n_tests++;
        if (d[7] !== 1'b1) begin n_fail++; $display("FAIL tx_ovf_flag: got %b expected 1", d[7]); end
        for (int i = 0; i < 16; i++) begin
            idle(0, 8'd0, 0, 0, 1);
            n_tests++;
            if (s_txd !== 8'(8'h41 + i)) begin
                n_fail++;
                $display("FAIL tx_pop_order[%0d]: got %h expected %h", i, s_txd, 8'(8'h41 + i));
            end
        end
        idle(0, 8'd0, 0, 0, 0);
        n_tests++;
        if (s_txv !== 1'b0) begin n_fail++; $display("FAIL tx_drained: got %b expected 0", s_txv); end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] d;
        logic e;
        logic [7:0] pushed[$];
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            pushed.push_back(b);
            idle(1, b, 0, 0, 0);
        end
        apb_rd(BASE + 32'h14, d, e);
        n_tests++;
        if (d !== 32'h10) begin n_fail++; $display("FAIL rx_count_full: got %h expected 10", d); end
        apb_rd(BASE + 32'h08, d, e);
        n_tests++;
        if (d !== 32'h117) begin n_fail++; $display("FAIL rx_ovr_stat: got %h expected 117", d); end
        apb_wr(BASE + 32'h08, 32'h10, e);
        apb_rd(BASE + 32'h08, d, e);
        n_tests++;
        if (d[4] !== 1'b0) begin n_fail++; $display("FAIL rx_ovr_w1c: got %b expected 0", d[4]); end
        for (int i = 0; i < 16; i++) begin
            apb_rd(BASE, d, e);
            n_tests++;
            if (d[7:0] !== pushed[i] || e !== 1'b0) begin
                n_fail++;
                $display("FAIL rx_read_order[%0d]: got %h err=%b expected %h", i, d[7:0], e, pushed[i]);
            end
        end
        apb_rd(BASE + 32'h14, d, e);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rx_count_empty: got %h expected 0", d); end
    endtask

    task automatic test_irq_thresh();
        logic [31:0] d;
        logic e;
        do_reset();
        apb_wr(BASE + 32'h0C, 32'h21, e);
        for (int i = 0; i < 4; i++) idle(1, 8'(i + 7), 0, 0, 0);
        idle(0, 8'd0, 0, 0, 0);
        idle(0, 8'd0, 0, 0, 0);
        n_tests++;
        if (s_irq !== 1'b1) begin n_fail++; $display("FAIL irq_thresh_set: got %b expected 1", s_irq); end
        apb_rd(BASE, d, e);
        idle(0, 8'd0, 0, 0, 0);
        idle(0, 8'd0, 0, 0, 0);
        n_tests++;
        if (s_irq !== 1'b0) begin n_fail++; $display("FAIL irq_thresh_clear: got %b expected 0", s_irq); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d;
        logic e;
        logic [7:0] first;
        do_reset();
        first = 8'($urandom);
        idle(1, first, 0, 0, 0);
        for (int i = 1; i < 16; i++) idle(1, 8'($urandom), 0, 0, 0);
        cycle(1, 0, BASE, 32'd0, 0, 8'd0, 0, 0, 0, d, e);
        cycle(2, 0, BASE, 32'd0, 1, 8'hA5, 0, 0, 0, d, e);
        n_tests++;
        if (d[7:0] !== first) begin n_fail++; $display("FAIL full_pop_push_data: got %h expected %h", d[7:0], first); end
        apb_rd(BASE + 32'h14, d, e);
        n_tests++;
        if (d[15:0] !== 16'd16) begin n_fail++; $display("FAIL full_pop_push_count: got %0d expected 16", d[15:0]); end
        apb_rd(BASE + 32'h08, d, e);
        n_tests++;
        if (d[4] !== 1'b0) begin n_fail++; $display("FAIL full_pop_push_ovr: got %b expected 0", d[4]); end
        cycle(1, 1, BASE + 32'h08, 32'h20, 0, 8'd0, 0, 0, 0, d, e);
        cycle(2, 1, BASE + 32'h08, 32'h20, 1, 8'h5A, 1, 0, 0, d, e);
        apb_rd(BASE + 32'h08, d, e);
        n_tests++;
        if (d[5] !== 1'b1) begin n_fail++; $display("FAIL par_set_beats_w1c: got %b expected 1", d[5]); end
    endtask

    task automatic test_tx_flush();
        logic [31:0] d;
        logic e;
        do_reset();
        for (int i = 0; i < 5; i++) apb_wr(BASE + 32'h04, $urandom, e);
        apb_wr(BASE + 32'h0C, 32'h200, e);
        idle(0, 8'd0, 0, 0, 0);
        n_tests++;
        if (s_txv !== 1'b0) begin n_fail++; $display("FAIL tx_flush_valid: got %b expected 0", s_txv); end
        apb_rd(BASE + 32'h14, d, e);
        n_tests++;
        if (d[31:16] !== 16'd0) begin n_fail++; $display("FAIL tx_flush_count: got %0d expected 0", d[31:16]); end
        apb_rd(BASE + 32'h0C, d, e);
        n_tests++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL ctrl_flush_reads_0: got %h expected 0", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic e;
        do_reset();
        apb_wr(BASE + 32'h10, 32'h1234, e);
        apb_wr(BASE + 32'h0C, 32'h1, e);
        for (int i = 0; i < 3; i++) apb_wr(BASE + 32'h04, 32'h60 + i, e);
        for (int i = 0; i < 3; i++) idle(1, 8'(i), 0, 0, 0);
        idle(0, 8'd0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        rx_valid = 1; tx_ready = 1;
        apb.psel = 1; apb.penable = 1; apb.pwrite = 1; apb.paddr = BASE + 32'h04; apb.pwdata = 32'h77;
        @(posedge clk);
        #1;
        n_tests++;
        if (tx_valid_o !== 1'b0 || irq_o !== 1'b0 || baud_div_o !== 16'd27) begin
            n_fail++;
            $display("FAIL mid_reset: got tx_valid=%b irq=%b baud=%0d expected 0 0 27", tx_valid_o, irq_o, baud_div_o);
        end
        @(negedge clk);
        apb.psel = 0; apb.penable = 0; rx_valid = 0; tx_ready = 0;
        rst_n = 1'b1;
        model_reset();
        apb_rd(BASE + 32'h14, d, e);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL mid_reset_level: got %h expected 0", d); end
        apb_rd(BASE + 32'h08, d, e);
        n_tests++;
        if (d !== 32'h004) begin n_fail++; $display("FAIL mid_reset_stat: got %h expected 004", d); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic e;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int k;
            bit rxv, pe, fe, txr, w;
            logic [31:0] a, wd;
            k   = int'($urandom_range(0, 4));
            rxv = ($urandom_range(0, 2) == 0);
            pe  = ($urandom_range(0, 7) == 0);
            fe  = ($urandom_range(0, 7) == 0);
            txr = ($urandom_range(0, 2) == 0);
            a   = BASE + 32'(4 * $urandom_range(0, 6));
            if (k == 4) a = $urandom;
            w   = ($urandom_range(0, 1) == 1);
            wd  = $urandom;
            if (a == BASE + 32'h0C && $urandom_range(0, 3) != 0) wd[9:8] = 2'b00;
            if (k == 0) begin
                idle(rxv, 8'($urandom), pe, fe, txr);
            end else begin
                cycle(1, w, a, wd, 0, 8'd0, 0, 0, 0, d, e);
                cycle(2, w, a, wd, rxv, 8'($urandom), pe, fe, txr, d, e);
            end
        end
    endtask

    initial begin
        apb.psel = 0; apb.penable = 0; apb.pwrite = 0; apb.paddr = 32'd0; apb.pwdata = 32'd0;
        model_reset();
        test_reset();
        test_tx_fill();
        test_rx_overflow();
        test_irq_thresh();
        test_same_cycle();
        test_tx_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
